// File: rtl/frame_mem_arbiter_if.sv
// Shared-memory bus bundle for frame_mem_arbiter.
// Carries the CPU request/acknowledge handshake and the single data-memory
// port that the CPU and the display prefetcher take turns on.
//   slave  : the arbiter side (takes CPU requests, drives the memory port)
//   master : the environment side (the CPU and the memory itself)
interface frame_mem_arbiter_if #(
  parameter int ADDR_W = 19
) ();
  // CPU handshake
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  // Data-memory port: combinational read, write on the clock edge
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Frame-buffer memory arbiter for a 640x480 grayscale VGA display.
// A single memory port is shared between a display prefetcher (which keeps a
// small word FIFO topped up) and a CPU. Each active raster cycle consumes one
// byte of the FIFO head word, LSB first.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   H_Count_Value, V_Count_Value   raster position from the VGA sync generator
//   pix_out, pix_valid             registered pixel stream
//   underrun                       sticky flag: a pixel was needed with FIFO empty
//   bus                            CPU handshake + shared memory port (slave side)
module frame_mem_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int FRAME_WORDS = 76800,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOW_WATER   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] H_Count_Value,
  input  logic [9:0] V_Count_Value,
  output logic [7:0] pix_out,
  output logic       pix_valid,
  output logic       underrun,
  frame_mem_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(LOW_WATER);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CPU  = 2'd2
  } grant_e;

  grant_e            grant;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [7:0]        pix_out_q;
  logic              pix_valid_q, underrun_q, cpu_ack_q;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       head_shifted;
  logic              active, frame_sync, fifo_empty, push, consume, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign active     = (H_Count_Value < 10'd640) && (V_Count_Value < 10'd480);
  assign frame_sync = (H_Count_Value == 10'd0) && (V_Count_Value == 10'd480);
  assign fifo_empty = (level_q == '0);

  // Grant is decided from the current FIFO level and CPU state and takes
  // effect in the same cycle, so a fill stops exactly when the FIFO is full.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (!rst_n)                          grant = GNT_NONE;
    else if (level_q < LOW_LVL)          grant = GNT_DISP;
    else if (bus.cpu_req && !cpu_ack_q)  grant = GNT_CPU;
    else if (level_q != FULL_LVL)        grant = GNT_DISP;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (grant)
      GNT_DISP: bus.mem_addr = fetch_ptr_q;
      GNT_CPU: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_we    = bus.cpu_we;
        bus.mem_wdata = bus.cpu_wdata;
      end
      default: ;
    endcase
  end

  // A display fetch in the frame-sync cycle is dropped: the FIFO is flushed.
  assign push    = (grant == GNT_DISP) && !frame_sync;
  assign consume = active && !fifo_empty;
  assign pop     = consume && (byte_idx_q == 2'd3);

  assign head_shifted = fifo_q[rd_ptr_q] >> {byte_idx_q, 3'b000};

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    fetch_ptr_d = fetch_ptr_q;
    if (grant == GNT_DISP)
      fetch_ptr_d = (fetch_ptr_q == LAST_WORD) ? '0 : fetch_ptr_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      byte_idx_q  <= '0;
      fetch_ptr_q <= '0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ack_q <= (grant == GNT_CPU);
      if ((grant == GNT_CPU) && !bus.cpu_we) cpu_rdata_q <= bus.mem_rdata;

      // An empty-FIFO active cycle still emits a (black) pixel but does not
      // advance the byte index, so the stream resumes on the byte it owed.
      pix_valid_q <= active;
      pix_out_q   <= consume ? head_shifted[7:0] : 8'd0;
      if (active && fifo_empty) underrun_q <= 1'b1;

      if (frame_sync) begin
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        level_q     <= '0;
        byte_idx_q  <= '0;
        fetch_ptr_q <= '0;
      end else begin
        if (push)    wr_ptr_q   <= ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_q   <= ptr_inc(rd_ptr_q);
        if (consume) byte_idx_q <= byte_idx_q + 2'd1;
        level_q     <= level_d;
        fetch_ptr_q <= fetch_ptr_d;
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; level and pointers
  // define which entries are valid, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.mem_rdata;
  end

  assign pix_out       = pix_out_q;
  assign pix_valid     = pix_valid_q;
  assign underrun      = underrun_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter. A short frame (48 words) is used
// so the fetch-pointer wrap is reached within a single scan line.
module tb_frame_mem_arbiter;
  localparam int FW = 48;
  localparam logic [31:0] G_NONE = 32'd0;
  localparam logic [31:0] G_DISP = 32'd1;
  localparam logic [31:0] G_CPU  = 32'd2;

  typedef struct packed {
    logic       valid;
    logic [7:0] pix;
  } pix_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_cnt, v_cnt;
  logic [7:0] pix_out;
  logic       pix_valid, underrun;

  frame_mem_arbiter_if #(.ADDR_W(19)) bus ();

  frame_mem_arbiter #(
    .ADDR_W(19), .FRAME_WORDS(FW), .FIFO_DEPTH(4), .LOW_WATER(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .H_Count_Value(h_cnt), .V_Count_Value(v_cnt),
    .pix_out(pix_out), .pix_valid(pix_valid), .underrun(underrun),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge
  logic [31:0] mem [512];
  assign bus.mem_rdata = mem[bus.mem_addr[8:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;

  // Inputs for the next cycle are staged here and applied at the falling edge
  logic        n_rst, n_req, n_we;
  logic [18:0] n_addr;
  logic [31:0] n_wdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pix_n;
  int          hp;
  logic [31:0] exp_fetch;
  logic [31:0] last_rdata;
  pix_exp_t    pix_q [$];
  logic [31:0] rd_q  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One clock cycle: compare last cycle's pixel, apply new inputs, push the
  // expected pixel, then check any display fetch address once settled.
  task automatic cycle(input logic [9:0] h, input logic [9:0] v, input bit und = 1'b0);
    pix_exp_t    e;
    logic [31:0] w;
    @(negedge clk);
    if (pix_q.size() != 0) begin
      e = pix_q.pop_front();
      check("pix_valid", 32'(pix_valid), 32'(e.valid));
      check("pix_out", 32'(pix_out), 32'(e.pix));
    end
    rst_n         = n_rst;
    bus.cpu_req   = n_req;
    bus.cpu_we    = n_we;
    bus.cpu_addr  = n_addr;
    bus.cpu_wdata = n_wdata;
    h_cnt = h;
    v_cnt = v;
    if (h < 10'd640 && v < 10'd480) begin
      e.valid = 1'b1;
      if (und) e.pix = 8'd0;
      else begin
        w = 32'((pix_n / 4) % FW);
        e.pix = w[7:0];
        pix_n++;
      end
    end else begin
      e.valid = 1'b0;
      e.pix   = 8'd0;
      if (h == 10'd0 && v == 10'd480) pix_n = 0;
    end
    pix_q.push_back(e);
    #1;
    if (32'(dut.grant) == G_DISP) begin
      check("fetch_addr", 32'(bus.mem_addr), exp_fetch);
      exp_fetch = (exp_fetch + 1) % FW;
    end
    if (h == 10'd0 && v == 10'd480) exp_fetch = 0;
  endtask

  task automatic cpu_xfer(input string tag, input bit we, input logic [18:0] addr,
                          input logic [31:0] data, input logic [9:0] v);
    bit got = 1'b0;
    n_req = 1'b1; n_we = we; n_addr = addr; n_wdata = data;
    if (we) rd_q.push_back(last_rdata);
    else begin
      rd_q.push_back(data);
      last_rdata = data;
    end
    cycle(10'(hp), v); hp++;
    for (int n = 0; n < 4 && !got; n++) begin
      cycle(10'(hp), v); hp++;
      if (bus.cpu_ack) begin
        got   = 1'b1;
        n_req = 1'b0;
        check({tag, "_rdata"}, bus.cpu_rdata, rd_q.pop_front());
      end
    end
    check({tag, "_ack_within_4"}, 32'(got), 32'd1);
    if (!got) begin
      n_req = 1'b0;
      rd_q.delete();
    end
    cycle(10'(hp), v); hp++;
    check({tag, "_ack_one_cycle"}, 32'(bus.cpu_ack), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 512; k++) begin
      logic [7:0] b;
      b = k[7:0];
      mem[k] = {4{b}};
    end
    n_rst = 1'b0; n_req = 1'b0; n_we = 1'b0; n_addr = '0; n_wdata = '0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    h_cnt = 10'd700; v_cnt = 10'd500;
    pix_n = 0; exp_fetch = 0; last_rdata = 0; hp = 0;

    // Reset state
    cycle(10'd700, 10'd500);
    cycle(10'd700, 10'd500);
    check("rst_pix_out",   32'(pix_out),      32'd0);
    check("rst_pix_valid", 32'(pix_valid),    32'd0);
    check("rst_underrun",  32'(underrun),     32'd0);
    check("rst_cpu_ack",   32'(bus.cpu_ack),  32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata,     32'd0);
    check("rst_mem_we",    32'(bus.mem_we),   32'd0);
    check("rst_grant",     32'(dut.grant),    G_NONE);
    check("rst_level",     32'(dut.level_q),  32'd0);

    // Fill after release in blanking: four display fetches at 0..3, then idle
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(10'd700, 10'd500);
      check("fill_grant", 32'(dut.grant), G_DISP);
      check("fill_addr", 32'(bus.mem_addr), 32'(k));
    end
    cycle(10'd700, 10'd500);
    check("fill_idle_grant", 32'(dut.grant), G_NONE);
    check("fill_level", 32'(dut.level_q), 32'd4);

    // Consume one word, then frame sync with the FIFO at level 3
    for (int k = 0; k < 4; k++) cycle(10'(k), 10'd0);
    cycle(10'd0, 10'd480);
    check("sync_level_before", 32'(dut.level_q), 32'd3);
    cycle(10'd1, 10'd480);
    check("sync_level_after", 32'(dut.level_q), 32'd0);
    check("sync_next_addr", 32'(bus.mem_addr), 32'd0);

    // Full active line from frame start (fetch pointer wraps several times)
    for (int h = 2; h < 8; h++) cycle(10'(h), 10'd480);
    for (int h = 0; h < 660; h++) cycle(10'(h), 10'd0);
    check("scan_underrun", 32'(underrun), 32'd0);

    // CPU write then read during active video
    hp = 0;
    while (hp < 20) begin cycle(10'(hp), 10'd1); hp++; end
    cpu_xfer("cpu_wr", 1'b1, 19'h100, 32'hDEADBEEF, 10'd1);
    cpu_xfer("cpu_rd", 1'b0, 19'h100, 32'hDEADBEEF, 10'd1);
    while (hp < 660) begin cycle(10'(hp), 10'd1); hp++; end
    check("cpu_underrun", 32'(underrun), 32'd0);

    // Reset asserted in the cycle a CPU write is granted
    for (int k = 0; k < 6; k++) cycle(10'd700, 10'd1);
    n_req = 1'b1; n_we = 1'b1; n_addr = 19'h101; n_wdata = 32'h12345678;
    cycle(10'd700, 10'd1);
    check("abort_grant", 32'(dut.grant), G_CPU);
    rst_n = 1'b0; n_rst = 1'b0; n_req = 1'b0; exp_fetch = 0;
    #1;
    check("abort_pix_out",   32'(pix_out),       32'd0);
    check("abort_pix_valid", 32'(pix_valid),     32'd0);
    check("abort_underrun",  32'(underrun),      32'd0);
    check("abort_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("abort_cpu_rdata", bus.cpu_rdata,      32'd0);
    check("abort_mem_we",    32'(bus.mem_we),    32'd0);
    check("abort_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("abort_mem_wdata", bus.mem_wdata,      32'd0);
    check("abort_grant_none", 32'(dut.grant),    G_NONE);
    check("abort_level",     32'(dut.level_q),   32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(10'd700, 10'd1);
      check("abort_no_ack", 32'(bus.cpu_ack), 32'd0);
    end
    check("abort_no_write", mem[9'h101], 32'h01010101);

    // Release straight into active video: first pixel underruns
    pix_n = 0; n_rst = 1'b1;
    cycle(10'd0, 10'd0, 1'b1);
    check("release_grant", 32'(dut.grant), G_DISP);
    for (int h = 1; h < 24; h++) cycle(10'(h), 10'd0);
    check("underrun_set", 32'(underrun), 32'd1);
    check("release_no_ack", 32'(bus.cpu_ack), 32'd0);
    for (int k = 0; k < 4; k++) cycle(10'd700, 10'd0);
    check("underrun_sticky", 32'(underrun), 32'd1);
    rst_n = 1'b0; n_rst = 1'b0;
    #1;
    check("underrun_cleared", 32'(underrun), 32'd0);
    cycle(10'd700, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
